// File: rtl/axi_slave_rd.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_rd
//  Purpose  : AXI4 read-channel slave. Accepts one INCR read burst on AR,
//             fetches each beat from a memory model with 1-cycle read latency
//             and returns the beats on R through a 2-entry buffer so that
//             rready back-pressure never loses or duplicates a beat.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             rd_addr/rd_len      - per-beat byte address, captured arlen
//             rd_en/rd_data       - beat request; data valid 1 cycle later
//             rd_done             - 1-cycle pulse after the last R handshake
//             s_axi_ar*           - AXI read address channel
//             s_axi_r*            - AXI read data channel
//  Revision : 1.0 - initial release
// ============================================================================
module axi_slave_rd #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // memory model port
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_len,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  // AR channel
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // R channel
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int STEP = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t                state;
  logic                  err;
  logic [8:0]            iss;       // beats requested from memory
  logic [8:0]            ret;       // beats handed over on R (head index)
  logic                  in_flight; // rd_en of previous cycle; data arrives now
  logic [DATA_WIDTH-1:0] beat0;
  logic [DATA_WIDTH-1:0] beat1;
  logic                  head;
  logic                  tail;
  logic [1:0]            count;

  logic                  pop;
  logic [2:0]            committed;

  // AR sideband attributes carry no meaning for this slave.
  logic unused_ar_attr;
  assign unused_ar_attr = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  assign s_axi_rvalid = (count != 2'd0);
  assign s_axi_rdata  = head ? beat1 : beat0;
  assign s_axi_rlast  = s_axi_rvalid && (ret == {1'b0, rd_len});
  assign s_axi_rresp  = err ? 2'b10 : 2'b00;
  assign pop          = s_axi_rvalid && s_axi_rready;

  // Buffer slots already spoken for once this cycle's pop is taken out: what
  // stays in the buffer plus the beat arriving from memory now. A new request
  // is only allowed if it will find a free slot even if the next cycle does not
  // pop. rd_en has to see this cycle's pop to sustain one beat per cycle, which
  // is why it is combinational rather than registered.
  assign committed = {1'b0, count} - {2'b00, pop} + {2'b00, in_flight};
  assign rd_en     = (state == RD) && (iss <= {1'b0, rd_len}) && (committed < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rid     <= '0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_done       <= 1'b0;
      err           <= 1'b0;
      iss           <= '0;
      ret           <= '0;
      in_flight     <= 1'b0;
      beat0         <= '0;
      beat1         <= '0;
      head          <= 1'b0;
      tail          <= 1'b0;
      count         <= '0;
    end else begin
      rd_done   <= 1'b0;
      in_flight <= rd_en;

      // Memory data for the previous cycle's request lands in the buffer.
      if (in_flight) begin
        if (tail) beat1 <= rd_data;
        else      beat0 <= rd_data;
        tail <= ~tail;
      end

      if (pop) begin
        head <= ~head;
        ret  <= ret + 9'd1;
      end

      count <= count + {1'b0, in_flight} - {1'b0, pop};

      if (rd_en) begin
        iss     <= iss + 9'd1;
        rd_addr <= rd_addr + ADDR_WIDTH'(STEP);
      end

      case (state)
        IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            state         <= RD;
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            rd_len        <= s_axi_arlen;
            rd_addr       <= s_axi_araddr;
            err           <= (s_axi_arsize != 3'd3) || (s_axi_arburst != 2'b01);
            iss           <= '0;
            ret           <= '0;
          end
        end
        RD: begin
          if (pop && s_axi_rlast) begin
            state         <= IDLE;
            s_axi_arready <= 1'b1;
            err           <= 1'b0;
            rd_done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
